// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared ALU definitions for the nibble-serial subtractor: the FSM state
// type, the default geometry and the helpers that derive the group count
// and the group index width from it.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned GROUP_DEFAULT = 4;

    function automatic int unsigned num_groups(input int unsigned width,
                                               input int unsigned group);
        return width / group;
    endfunction

    // Index counter width; kept at least 1 bit so a single-group build
    // still has a legal register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_group_sub_slice.sv
// Combinational GROUP-bit lookahead slice.
// Ports:
//   p         - per-bit propagate (a ^ nb)
//   g         - per-bit generate  (a & nb)
//   carry_in  - carry into bit 0 of the group
//   sum       - p ^ carry for each bit
//   carry_out - carry out of the top bit
// Every internal carry is a flat sum of products (AND level, then OR level)
// rather than a ripple, so depth stays two gates regardless of GROUP.
module group_sub_slice #(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             carry_in,
    output logic [GROUP-1:0] sum,
    output logic             carry_out
);

    // w_gc[0] is the incoming carry, w_gc[j] the generate of bit j-1, so a
    // term starting at position j is w_gc[j] propagated through p[j..i].
    logic [GROUP:0] w_gc;
    logic [GROUP:0] w_c;
    logic           w_prod;

    assign w_gc = {g, carry_in};

    always_comb begin
        w_c    = '0;
        w_prod = 1'b0;
        w_c[0] = carry_in;
        for (int unsigned i = 0; i < GROUP; i++) begin
            w_c[i+1] = g[i];
            for (int unsigned j = 0; j <= i; j++) begin
                w_prod = w_gc[j];
                for (int unsigned k = j; k <= i; k++) begin
                    w_prod = w_prod & p[k];
                end
                w_c[i+1] = w_c[i+1] | w_prod;
            end
        end
    end

    assign sum       = p ^ w_c[GROUP-1:0];
    assign carry_out = w_c[GROUP];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b (mod 2^WIDTH), evaluated as
// a + ~b + 1 one GROUP-bit slice per clock, the inter-group carry held in
// a register.
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_valid / in_ready - operand handshake (accepted only in IDLE)
//   a, b                - minuend, subtrahend (latched at acceptance)
//   out_valid/out_ready - result handshake (result held while in DONE)
//   diff                - a - b modulo 2^WIDTH
//   borrow              - unsigned underflow (a < b)
//   overflow            - signed two's-complement overflow
module nibble_serial_subtractor
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned GROUP = GROUP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int unsigned NUM_GROUPS = num_groups(WIDTH, GROUP);
    localparam int unsigned IDX_W      = idx_width(NUM_GROUPS);
    localparam int unsigned MSB        = WIDTH - 1;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_nb;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_overflow;

    logic [GROUP-1:0]   w_a_grp;
    logic [GROUP-1:0]   w_nb_grp;
    logic [GROUP-1:0]   w_sum;
    logic               w_cout;
    logic               w_last;

    assign w_a_grp  = r_a[r_idx*GROUP +: GROUP];
    assign w_nb_grp = r_nb[r_idx*GROUP +: GROUP];
    assign w_last   = (r_idx == IDX_W'(NUM_GROUPS - 1));

    group_sub_slice #(
        .GROUP(GROUP)
    ) u_slice (
        .p        (w_a_grp ^ w_nb_grp),
        .g        (w_a_grp & w_nb_grp),
        .carry_in (r_carry),
        .sum      (w_sum),
        .carry_out(w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_nb       <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_diff[r_idx*GROUP +: GROUP] <= w_sum;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        // Top slice is being written this edge, so the new
                        // MSB comes from w_sum, not from r_diff.
                        r_borrow   <= ~w_cout;
                        r_overflow <= (r_a[MSB] != ~r_nb[MSB]) &
                                      (w_sum[GROUP-1] != r_a[MSB]);
                        r_idx      <= '0;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] d;
        logic        br;
        logic        ov;
    } exp_t;

    exp_t exp_q[$];

    nibble_serial_subtractor #(
        .WIDTH(16),
        .GROUP(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer subtraction, unsigned and signed views.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   sd;
        e.d  = x - y;
        e.br = (x < y);
        sd   = int'($signed(x)) - int'($signed(y));
        e.ov = (sd > 32767) || (sd < -32768);
        return e;
    endfunction

    // Scoreboard bookkeeping from observed handshakes.
    always @(posedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
        end
    end

    always @(negedge rst_n) exp_q.delete();

    // Every cycle with a valid result is checked against the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("model_diff", {16'd0, diff}, {16'd0, exp_q[0].d});
                check("model_borrow", {31'd0, borrow}, {31'd0, exp_q[0].br});
                check("model_overflow", {31'd0, overflow}, {31'd0, exp_q[0].ov});
            end
        end
    end

    // Accept one operation, verify latency and busy in_ready, compare the
    // result to hand-computed literals, then drain it.
    task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                         input logic [15:0] ed, input logic eb, input logic eo,
                         input int hold_cycles);
        int cnt;
        logic [15:0] sd;
        logic sb, so;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'h5A5A;
        cnt      = 1;
        while (!out_valid && cnt < 20) begin
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            cnt++;
        end
        check("latency", cnt - 1, 32'd4);
        check("lit_diff", {16'd0, diff}, {16'd0, ed});
        check("lit_borrow", {31'd0, borrow}, {31'd0, eb});
        check("lit_overflow", {31'd0, overflow}, {31'd0, eo});
        sd = diff;
        sb = borrow;
        so = overflow;
        if (hold_cycles > 0) begin
            in_valid = 1'b1;
            a        = 16'h0F0F;
            b        = 16'h0101;
            for (int i = 0; i < hold_cycles; i++) begin
                @(negedge clk);
                check("hold_out_valid", {31'd0, out_valid}, 32'd1);
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
                check("hold_diff", {16'd0, diff}, {16'd0, sd});
                check("hold_flags", {30'd0, borrow, overflow}, {30'd0, sb, so});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff", {16'd0, diff}, 32'd0);
        check("rst_flags", {30'd0, borrow, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 0);
        do_op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 0);
        do_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 0);
        do_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 0);
        do_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 3);
        do_op(16'h00FF, 16'h000F, 16'h00F0, 1'b0, 1'b0, 0);
        do_op(16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 0);
        do_op(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 0);

        // Reset two groups into a run.
        @(negedge clk);
        a        = 16'h1234;
        b        = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_diff", {16'd0, diff}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h00FF, 16'h0000, 1'b0, 1'b0, 0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle 16-bit subtractor computing diff = a - b, one 4-bit group per clock.
- Uses the same group propagate/generate lookahead as the team's 16-bit adder, run as a + ~b + 1.
- Sits beside the adder in the ALU datapath as its inverse operation.
- Trades latency for area; the group carry is held in a register between cycles.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand and result width.
- GROUP, 4, bits processed per cycle. Must divide WIDTH; NUM_GROUPS = WIDTH/GROUP.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  a - b, modulo 2^WIDTH.
- borrow  output  1  unsigned underflow (a < b).
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- The only clock is clk. Reset is rst_n: asynchronous assert, active-low; deassertion is synchronous to clk.
- Reset values:
  - state = IDLE, group index = 0, carry register = 0.
  - diff = 0, borrow = 0, overflow = 0, out_valid = 0.
  - in_ready = 1, because in_ready is decoded from state (IDLE).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: latch a and ~b, set index = 0, set carry = 1, go to RUN.
  - After acceptance, later changes on a and b are ignored.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, group k uses p = a_k ^ nb_k and g = a_k & nb_k with carry-in = carry register.
  - The 4-bit lookahead sum is written to diff[k*GROUP +: GROUP]; carry-out is stored in the carry register; index increments.
  - On the edge that completes group NUM_GROUPS-1:
    - borrow <= ~carry_out.
    - overflow <= (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the newly computed MSB.
    - Go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - diff, borrow and overflow are held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_valid in this state is ignored; there is no back-to-back accept.
- Latency and throughput:
  - Accept at edge T; out_valid is high after edge T+NUM_GROUPS (T+4 with defaults).
  - Minimum spacing between accepts is NUM_GROUPS+2 cycles.
- Intermediate results: diff may change during RUN. Outputs are defined only while out_valid = 1.
- Carry chain: the carry register carries the borrow across all groups. 0x1000 - 0x0001 must ripple through every group.
- Reset mid-operation: RUN or DONE is aborted immediately. All outputs return to reset values; no partial result is emitted.
- out_ready while out_valid = 0: no effect.

Decomposition:
- Shared package alu_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - constants WIDTH_DEFAULT = 16, GROUP_DEFAULT = 4;
  - the NUM_GROUPS derivation;
  - the index width, clog2(NUM_GROUPS).
- One combinational sub-module, group_sub_slice:
  - inputs: GROUP-bit p, GROUP-bit g, carry_in;
  - outputs: GROUP-bit sum, carry_out;
  - two-level lookahead, instantiated once.
- The top level holds the FSM, the operand registers, the index counter, the carry register and the result registers.

Test Plan:
- Basic: a = 0x1234, b = 0x0234 accepted at T -> out_valid after T+4; diff = 0x1000, borrow = 0, overflow = 0; in_ready = 0 during T+1..T+4.
- Borrow ripple: 0x1000 - 0x0001 -> diff 0x0FFF, borrow 0, overflow 0. Then 0x0000 - 0x0001 -> diff 0xFFFF, borrow 1, overflow 0.
- Signed overflow: 0x8000 - 0x0001 -> diff 0x7FFF, borrow 0, overflow 1. Then 0x7FFF - 0xFFFF -> diff 0x8000, borrow 1, overflow 1.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE with in_valid = 1 and a new a/b -> outputs stable, in_ready = 0, new operands not taken. Then out_ready = 1 -> IDLE next cycle, in_ready = 1.
- Operand change after accept: accept 0x00FF - 0x000F, then drive a = 0xFFFF during RUN -> diff 0x00F0, borrow 0.
- Reset mid-RUN: assert rst_n low after 2 groups -> out_valid 0, diff 0, in_ready 1 immediately (asynchronously). Next 0x00FF - 0x00FF -> diff 0x0000, borrow 0, overflow 0.
